if_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 16-bit ThinPad CPU: owns the PC, issues fetch requests to the

---
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch port: req/addr out, ack/rdata back.
// The fetch unit is the master; the memory responder is the slave.
interface if_fetch_unit_if;
  logic        req;
  logic [15:0] addr;
  logic        ack;
  logic [15:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// ThinPad IF stage: PC, req/ack fetch FSM and IF/ID register.
// Optional IF_PERF_CNT_EN adds a saturating bubble counter output.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  mem_conflict_i,
  input  logic                  redirect_i,
  input  logic [15:0]           redirect_pc_i,
  if_fetch_unit_if.master       imem,
  output logic                  id_valid_o,
  output logic [15:0]           id_instr_o,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]           id_pc_o,
  output logic [31:0]           perf_bubbles_o
`else
  output logic [15:0]           id_pc_o
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    K_KEEP,
    K_LOAD,
    K_BUB
  } kind_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] tgt;
  logic [15:0] hbuf;
  logic        req;
  logic        fire;
  logic        accept;
  kind_t       kind;
  logic [15:0] ld_instr;
  logic [15:0] ld_pc;

  assign pc_inc = pc + 16'd1;

  always_comb begin
    req = 1'b0;
    unique case (state)
      S_FETCH: req = !mem_conflict_i;
      S_WAIT:  req = 1'b1;
      S_DRAIN: req = 1'b1;
      default: req = 1'b0;
    endcase
    if (!rst) req = 1'b0;
  end

  assign imem.req  = req;
  assign imem.addr = pc;
  assign fire      = req & imem.ack;
  assign accept    = fire & (state != S_DRAIN);

  // Redirect flushes even under stall; stall beats any load.
  always_comb begin
    kind     = K_BUB;
    ld_instr = imem.rdata;
    ld_pc    = pc_inc;
    if (redirect_i) begin
      kind = K_BUB;
    end else if (stall_i) begin
      kind = K_KEEP;
    end else if (accept) begin
      kind = K_LOAD;
    end else if (state == S_HOLD) begin
      kind     = K_LOAD;
      ld_instr = hbuf;
      ld_pc    = pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      tgt   <= 16'h0000;
      hbuf  <= NOP_INSTR;
    end else begin
      unique case (state)
        S_FETCH, S_WAIT: begin
          if (!req) begin
            if (redirect_i) pc <= redirect_pc_i;
          end else if (imem.ack) begin
            if (redirect_i) begin
              pc    <= redirect_pc_i;
              state <= S_FETCH;
            end else if (stall_i) begin
              pc    <= pc_inc;
              hbuf  <= imem.rdata;
              state <= S_HOLD;
            end else begin
              pc    <= pc_inc;
              state <= S_FETCH;
            end
          end else if (redirect_i) begin
            tgt   <= redirect_pc_i;
            state <= S_DRAIN;
          end else begin
            state <= S_WAIT;
          end
        end
        S_DRAIN: begin
          if (imem.ack) begin
            pc    <= redirect_i ? redirect_pc_i : tgt;
            state <= S_FETCH;
          end else if (redirect_i) begin
            tgt <= redirect_pc_i;
          end
        end
        S_HOLD: begin
          if (redirect_i) begin
            pc    <= redirect_pc_i;
            state <= S_FETCH;
          end else if (!stall_i) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_o <= 1'b0;
      id_instr_o <= NOP_INSTR;
      id_pc_o    <= 16'h0000;
    end else begin
      unique case (1'b1)
        kind == K_LOAD: begin
          id_valid_o <= 1'b1;
          id_instr_o <= ld_instr;
          id_pc_o    <= ld_pc;
        end
        kind == K_BUB: begin
          id_valid_o <= 1'b0;
          id_instr_o <= NOP_INSTR;
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bubbles_o <= 32'h0;
    end else if (kind == K_BUB && perf_bubbles_o != 32'hFFFF_FFFF) begin
      perf_bubbles_o <= perf_bubbles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, redirect/drain,
// stall/hold, mem conflict, PC wrap and async reset.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        mem_conflict_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        id_valid_o;
  logic [15:0] id_instr_o;
  logic [15:0] id_pc_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_bubbles_o;
`endif

  logic        auto;
  logic        ack_man;
  logic [15:0] rd_man;

  int n_chk  = 0;
  int n_fail = 0;

  if_fetch_unit_if imem ();

  assign imem.ack   = auto ? imem.req : ack_man;
  assign imem.rdata = auto ? (imem.addr + 16'h1000) : rd_man;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .mem_conflict_i (mem_conflict_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem           (imem.master),
    .id_valid_o     (id_valid_o),
    .id_instr_o     (id_instr_o),
`ifdef IF_PERF_CNT_EN
    .id_pc_o        (id_pc_o),
    .perf_bubbles_o (perf_bubbles_o)
`else
    .id_pc_o        (id_pc_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag,
                        input logic v,
                        input logic [15:0] ins,
                        input logic [15:0] pcv);
    chk({tag, ".valid"}, {31'd0, id_valid_o}, {31'd0, v});
    chk({tag, ".instr"}, {16'd0, id_instr_o}, {16'd0, ins});
    chk({tag, ".pc"},    {16'd0, id_pc_o},    {16'd0, pcv});
  endtask

  task automatic chk_req(input string tag,
                         input logic r,
                         input logic [15:0] a);
    chk({tag, ".req"}, {31'd0, imem.req}, {31'd0, r});
    if (r) chk({tag, ".addr"}, {16'd0, imem.addr}, {16'd0, a});
  endtask

  initial begin
    rst            = 1'b0;
    stall_i        = 1'b0;
    mem_conflict_i = 1'b0;
    redirect_i     = 1'b0;
    redirect_pc_i  = 16'h0000;
    auto           = 1'b1;
    ack_man        = 1'b0;
    rd_man         = 16'h0000;

    // reset state
    tick;
    tick;
    chk_req("rst", 1'b0, 16'h0000);
    chk_id("rst", 1'b0, 16'h0800, 16'h0000);

    // 1: zero-bubble streaming with combinational ack
    rst = 1'b1;
    #1;
    chk_req("t1.c0", 1'b1, 16'h0000);
    tick;
    chk_id("t1.c1", 1'b1, 16'h1000, 16'h0001);
    chk_req("t1.c1", 1'b1, 16'h0001);
    tick;
    chk_id("t1.c2", 1'b1, 16'h1001, 16'h0002);
    chk_req("t1.c2", 1'b1, 16'h0002);

    // 5: redirect with same-cycle ack, then wrap at FFFF
    redirect_i    = 1'b1;
    redirect_pc_i = 16'hFFFF;
    tick;
    redirect_i = 1'b0;
    chk_id("t5.flush", 1'b0, 16'h0800, 16'h0002);
    chk_req("t5.flush", 1'b1, 16'hFFFF);
    tick;
    chk_id("t5.wrap", 1'b1, 16'h0FFF, 16'h0000);
    chk_req("t5.wrap", 1'b1, 16'h0000);
    tick;
    chk_id("t5.next", 1'b1, 16'h1000, 16'h0001);

    // 3: stall across fetch, ack into hold buffer, release
    auto    = 1'b0;
    ack_man = 1'b0;
    stall_i = 1'b1;
    tick;
    chk_id("t3.s1", 1'b1, 16'h1000, 16'h0001);
    chk_req("t3.s1", 1'b1, 16'h0001);
    ack_man = 1'b1;
    rd_man  = 16'h4907;
    tick;
    ack_man = 1'b0;
    chk_id("t3.s2", 1'b1, 16'h1000, 16'h0001);
    chk_req("t3.s2", 1'b0, 16'h0000);
    tick;
    chk_id("t3.s3", 1'b1, 16'h1000, 16'h0001);
    chk_req("t3.s3", 1'b0, 16'h0000);
    stall_i = 1'b0;
    tick;
    chk_id("t3.rel", 1'b1, 16'h4907, 16'h0002);
    chk_req("t3.rel", 1'b1, 16'h0002);
    auto = 1'b1;
    tick;
    chk_id("t3.next", 1'b1, 16'h1002, 16'h0003);

    // 2: redirect during WAIT -> DRAIN, old data dropped
    auto    = 1'b0;
    ack_man = 1'b0;
    tick;
    chk_id("t2.wait", 1'b0, 16'h0800, 16'h0003);
    chk_req("t2.wait", 1'b1, 16'h0003);
    redirect_i    = 1'b1;
    redirect_pc_i = 16'h0040;
    tick;
    redirect_i = 1'b0;
    chk_id("t2.drain", 1'b0, 16'h0800, 16'h0003);
    chk_req("t2.drain", 1'b1, 16'h0003);
    ack_man = 1'b1;
    rd_man  = 16'hDEAD;
    tick;
    ack_man = 1'b0;
    chk_id("t2.drop", 1'b0, 16'h0800, 16'h0003);
    chk_req("t2.drop", 1'b1, 16'h0040);
    auto = 1'b1;
    tick;
    chk_id("t2.new", 1'b1, 16'h1040, 16'h0041);

    // 4: conflict in FETCH blocks issue and inserts bubbles
    mem_conflict_i = 1'b1;
    #1;
    chk_req("t4.c0", 1'b0, 16'h0000);
    tick;
    chk_id("t4.b1", 1'b0, 16'h0800, 16'h0041);
    chk_req("t4.b1", 1'b0, 16'h0000);
    tick;
    chk_id("t4.b2", 1'b0, 16'h0800, 16'h0041);
    mem_conflict_i = 1'b0;
    #1;
    chk_req("t4.res", 1'b1, 16'h0041);
    tick;
    chk_id("t4.load", 1'b1, 16'h1041, 16'h0042);

    // 4b: conflict while in WAIT keeps request stable
    auto    = 1'b0;
    ack_man = 1'b0;
    tick;
    mem_conflict_i = 1'b1;
    #1;
    chk_req("t4.w1", 1'b1, 16'h0042);
    tick;
    chk_req("t4.w2", 1'b1, 16'h0042);
    ack_man = 1'b1;
    rd_man  = 16'h1234;
    tick;
    ack_man        = 1'b0;
    mem_conflict_i = 1'b0;
    chk_id("t4.wacc", 1'b1, 16'h1234, 16'h0043);

    // 6: async reset in the middle of WAIT
    tick;
    chk_req("t6.wait", 1'b1, 16'h0043);
    rst = 1'b0;
    #1;
    chk_req("t6.rst", 1'b0, 16'h0000);
    chk_id("t6.rst", 1'b0, 16'h0800, 16'h0000);
`ifdef IF_PERF_CNT_EN
    chk("t6.perf0", perf_bubbles_o, 32'd0);
`endif
    tick;
    rst  = 1'b1;
    auto = 1'b1;
    #1;
    chk_req("t6.rel", 1'b1, 16'h0000);
    tick;
    chk_id("t6.first", 1'b1, 16'h1000, 16'h0001);
`ifdef IF_PERF_CNT_EN
    mem_conflict_i = 1'b1;
    tick;
    tick;
    mem_conflict_i = 1'b0;
    chk("t6.perf2", perf_bubbles_o, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
